// File: rtl/dbg_program_loader.sv
// Debug program loader: buffers host instruction words and writes them into core
// instruction memory at auto-incremented addresses while holding the core in reset.
module dbg_program_loader #(
    parameter int unsigned XLEN               = 64,
    parameter int unsigned INSTRUCTION_LENGTH = 32,
    parameter int unsigned FIFO_DEPTH         = 4,
    parameter int unsigned SETUP_CYCLES       = 2,
    parameter int unsigned GAP_CYCLES         = 1,
    parameter int unsigned MAX_WORDS          = 1024,
    localparam int unsigned CNT_W             = $clog2(MAX_WORDS + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [XLEN-1:0]               load_base,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INSTRUCTION_LENGTH-1:0] in_instr,
    input  logic                          in_last,
    output logic                          dbg_wr_en,
    output logic [XLEN-1:0]               dbg_addr,
    output logic [INSTRUCTION_LENGTH-1:0] dbg_instr,
    output logic                          core_rst,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [CNT_W-1:0]              word_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned TMAX  = (SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES;
    localparam int unsigned TW    = $clog2(TMAX + 1);

    typedef enum logic [2:0] {StIdle, StWait, StSetup, StStrobe, StGap, StFinish} state_e;

    state_e                        state_q, state_d;
    logic [XLEN-1:0]               addr_q, addr_d;
    logic [XLEN-1:0]               dbg_addr_q, dbg_addr_d;
    logic [INSTRUCTION_LENGTH-1:0] dbg_instr_q, dbg_instr_d;
    logic                          last_q, last_d;
    logic [TW-1:0]                 tmr_q, tmr_d;
    logic [CNT_W-1:0]              wc_q, wc_d;
    logic                          err_q, err_d;
    logic                          core_rst_q, core_rst_d;
    logic                          wr_en_q, wr_en_d;
    logic                          done_q, done_d;

    logic [INSTRUCTION_LENGTH-1:0] fifo_instr_q [FIFO_DEPTH];
    logic                          fifo_last_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]              wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PTR_W:0]                fcnt_q, fcnt_d;
    logic                          fifo_full, fifo_empty, push, pop, flush;

    assign fifo_full  = (fcnt_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign fifo_empty = (fcnt_q == '0);
    assign in_ready   = (state_q != StIdle) && (state_q != StFinish) && !fifo_full;
    assign push       = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr_q[wptr_q] <= in_instr;
            fifo_last_q[wptr_q]  <= in_last;
        end
    end

    // Flush wins over a simultaneous push or pop.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        fcnt_d = fcnt_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            fcnt_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            fcnt_d = fcnt_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        dbg_addr_d  = dbg_addr_q;
        dbg_instr_d = dbg_instr_q;
        last_d      = last_q;
        tmr_d       = tmr_q;
        wc_d        = wc_q;
        err_d       = err_q;
        core_rst_d  = core_rst_q;
        wr_en_d     = 1'b0;
        done_d      = 1'b0;
        pop         = 1'b0;
        flush       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d     = load_base;
                    wc_d       = '0;
                    err_d      = 1'b0;
                    flush      = 1'b1;
                    core_rst_d = 1'b1;
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (wc_q == CNT_W'(MAX_WORDS)) begin
                        // Overflow: drop the word and abort with the core still held.
                        err_d   = 1'b1;
                        flush   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        dbg_instr_d = fifo_instr_q[rptr_q];
                        dbg_addr_d  = addr_q;
                        last_d      = fifo_last_q[rptr_q];
                        tmr_d       = TW'(SETUP_CYCLES - 1);
                        state_d     = StSetup;
                    end
                end
            end
            StSetup: begin
                if (tmr_q == '0) begin
                    wr_en_d = 1'b1;
                    state_d = StStrobe;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            StStrobe: begin
                wc_d    = wc_q + CNT_W'(1);
                tmr_d   = TW'(GAP_CYCLES - 1);
                state_d = StGap;
            end
            StGap: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TW'(1);
                end else if (last_q) begin
                    done_d  = 1'b1;
                    state_d = StFinish;
                end else begin
                    addr_d  = addr_q + XLEN'(INSTRUCTION_LENGTH / 8);
                    state_d = StWait;
                end
            end
            StFinish: begin
                core_rst_d = 1'b0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            dbg_addr_q  <= '0;
            dbg_instr_q <= '0;
            last_q      <= 1'b0;
            tmr_q       <= '0;
            wc_q        <= '0;
            err_q       <= 1'b0;
            core_rst_q  <= 1'b1;
            wr_en_q     <= 1'b0;
            done_q      <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            fcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            dbg_addr_q  <= dbg_addr_d;
            dbg_instr_q <= dbg_instr_d;
            last_q      <= last_d;
            tmr_q       <= tmr_d;
            wc_q        <= wc_d;
            err_q       <= err_d;
            core_rst_q  <= core_rst_d;
            wr_en_q     <= wr_en_d;
            done_q      <= done_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            fcnt_q      <= fcnt_d;
        end
    end

    assign dbg_wr_en  = wr_en_q;
    assign dbg_addr   = dbg_addr_q;
    assign dbg_instr  = dbg_instr_q;
    assign core_rst   = core_rst_q;
    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign err        = err_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_dbg_program_loader.sv
// Bench for dbg_program_loader: cycle table for a single-word load plus directed
// sequences for streaming, address wrap, overflow, abort and restart.
module tb_dbg_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [63:0] load_base = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        in_last = 1'b0;
    logic        sel = 1'b0;

    logic        in_valid_a, in_valid_b;
    logic        ready_a, wr_a, crst_a, busy_a, done_a, err_a;
    logic [63:0] addr_a;
    logic [31:0] instr_a;
    logic [10:0] wc_a;
    logic        ready_b, wr_b, crst_b, busy_b, done_b, err_b;
    logic [63:0] addr_b;
    logic [31:0] instr_b;
    logic [1:0]  wc_b;

    assign in_valid_a = in_valid & ~sel;
    assign in_valid_b = in_valid & sel;

    always #5 clk = ~clk;

    dbg_program_loader dut_a (
        .clk(clk), .rst(rst), .start(start), .load_base(load_base),
        .in_valid(in_valid_a), .in_ready(ready_a), .in_instr(in_instr), .in_last(in_last),
        .dbg_wr_en(wr_a), .dbg_addr(addr_a), .dbg_instr(instr_a), .core_rst(crst_a),
        .busy(busy_a), .done(done_a), .err(err_a), .word_count(wc_a)
    );

    dbg_program_loader #(.MAX_WORDS(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .load_base(load_base),
        .in_valid(in_valid_b), .in_ready(ready_b), .in_instr(in_instr), .in_last(in_last),
        .dbg_wr_en(wr_b), .dbg_addr(addr_b), .dbg_instr(instr_b), .core_rst(crst_b),
        .busy(busy_b), .done(done_b), .err(err_b), .word_count(wc_b)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          ndone_a = 0, ndone_b = 0, nstrobe_b = 0, nstall_a = 0;
    int          q_cyc[$];
    logic [63:0] q_addr[$];
    logic [31:0] q_instr[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (wr_a) begin
            q_cyc.push_back(cyc);
            q_addr.push_back(addr_a);
            q_instr.push_back(instr_a);
        end
        if (wr_b) nstrobe_b <= nstrobe_b + 1;
        if (done_a) ndone_a <= ndone_a + 1;
        if (done_b) ndone_b <= ndone_b + 1;
        if (busy_a && !ready_a && !done_a) nstall_a <= nstall_a + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w, input logic last);
        int t = 0;
        in_valid = 1'b1;
        in_instr = w;
        in_last  = last;
        while (!(sel ? ready_b : ready_a) && t < 200) begin
            tick();
            t++;
        end
        chk("push_timeout", 64'(t < 200), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input logic b);
        int t = 0;
        tick();
        while ((b ? busy_b : busy_a) && t < 500) begin
            tick();
            t++;
        end
        chk("idle_timeout", 64'(t < 500), 64'd1);
    endtask

    task automatic do_start(input logic [63:0] base);
        load_base = base;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    typedef struct {
        logic        start, valid, last;
        logic [31:0] instr;
        logic        ready, wr, crst, busy, done;
        logic [63:0] addr;
        logic [31:0] dinstr;
        logic [10:0] wc;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic v, input logic [31:0] i, input logic l,
                                input logic r, input logic w, input logic c, input logic b,
                                input logic d, input logic [63:0] a, input logic [31:0] di,
                                input logic [10:0] wc);
        vec_t x;
        x.start = s; x.valid = v; x.instr = i; x.last = l;
        x.ready = r; x.wr = w; x.crst = c; x.busy = b; x.done = d;
        x.addr = a; x.dinstr = di; x.wc = wc;
        return x;
    endfunction

    vec_t        tbl[11];
    logic [31:0] prog[9];
    int          sb, db;

    initial begin
        prog = '{32'h00100093, 32'h0020A113, 32'h0030B193, 32'h0040C213, 32'h0050E293,
                 32'h0060F313, 32'h00709393, 32'h0080D413, 32'h4090D493};
        // Inputs for the next edge; outputs expected before that edge.
        tbl[0]  = mk(1, 0, 0,            0, 0, 0, 1, 0, 0, 0, 0,            0);
        tbl[1]  = mk(0, 1, 32'h00100093, 1, 1, 0, 1, 1, 0, 0, 0,            0);
        tbl[2]  = mk(0, 0, 0,            0, 1, 0, 1, 1, 0, 0, 0,            0);
        tbl[3]  = mk(0, 0, 0,            0, 1, 0, 1, 1, 0, 0, 32'h00100093, 0);
        tbl[4]  = mk(0, 0, 0,            0, 1, 0, 1, 1, 0, 0, 32'h00100093, 0);
        tbl[5]  = mk(0, 0, 0,            0, 1, 1, 1, 1, 0, 0, 32'h00100093, 0);
        tbl[6]  = mk(0, 0, 0,            0, 1, 0, 1, 1, 0, 0, 32'h00100093, 1);
        tbl[7]  = mk(0, 0, 0,            0, 0, 0, 1, 1, 1, 0, 32'h00100093, 1);
        tbl[8]  = mk(0, 1, 32'hBAD0BAD0, 0, 0, 0, 0, 0, 0, 0, 32'h00100093, 1);
        tbl[9]  = mk(0, 1, 32'hBAD0BAD0, 0, 0, 0, 0, 0, 0, 0, 32'h00100093, 1);
        tbl[10] = mk(0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 32'h00100093, 1);

        // Reset held for two cycles.
        tick();
        tick();
        chk("rst.core_rst", crst_a, 1);
        chk("rst.wr_en", wr_a, 0);
        chk("rst.in_ready", ready_a, 0);
        chk("rst.busy", busy_a, 0);
        chk("rst.word_count", wc_a, 0);
        chk("rst.dbg_addr", addr_a, 0);
        rst = 1'b1;
        tick();

        // Single-word load, cycle by cycle.
        load_base = '0;
        for (int i = 0; i < 11; i++) begin
            tick();
            chk($sformatf("v%0d.in_ready", i), ready_a, tbl[i].ready);
            chk($sformatf("v%0d.wr_en", i), wr_a, tbl[i].wr);
            chk($sformatf("v%0d.core_rst", i), crst_a, tbl[i].crst);
            chk($sformatf("v%0d.busy", i), busy_a, tbl[i].busy);
            chk($sformatf("v%0d.done", i), done_a, tbl[i].done);
            chk($sformatf("v%0d.dbg_addr", i), addr_a, tbl[i].addr);
            chk($sformatf("v%0d.dbg_instr", i), instr_a, tbl[i].dinstr);
            chk($sformatf("v%0d.word_count", i), wc_a, 64'(tbl[i].wc));
            start    = tbl[i].start;
            in_valid = tbl[i].valid;
            in_instr = tbl[i].instr;
            in_last  = tbl[i].last;
        end

        // Nine-word program streamed back-to-back.
        sb = q_addr.size();
        db = ndone_a;
        nstall_a = nstall_a;
        begin
            int st0;
            st0 = nstall_a;
            do_start(64'h0);
            for (int i = 0; i < 9; i++) push_word(prog[i], i == 8);
            wait_idle(1'b0);
            chk("nine.strobes", 64'(q_addr.size() - sb), 9);
            for (int i = 0; i < 9 && sb + i < q_addr.size(); i++) begin
                chk($sformatf("nine.addr%0d", i), q_addr[sb+i], 64'(4 * i));
                chk($sformatf("nine.instr%0d", i), q_instr[sb+i], prog[i]);
                if (i > 0)
                    chk($sformatf("nine.gap%0d", i), 64'(q_cyc[sb+i] - q_cyc[sb+i-1]), 5);
            end
            chk("nine.fifo_stall", 64'(nstall_a > st0), 1);
        end
        chk("nine.word_count", wc_a, 9);
        chk("nine.done_pulses", 64'(ndone_a - db), 1);
        chk("nine.core_rst", crst_a, 0);
        chk("nine.err", err_a, 0);

        // Address wrap-around.
        sb = q_addr.size();
        do_start(64'hFFFF_FFFF_FFFF_FFFC);
        push_word(32'h11111111, 1'b0);
        push_word(32'h22222222, 1'b1);
        wait_idle(1'b0);
        chk("wrap.strobes", 64'(q_addr.size() - sb), 2);
        if (q_addr.size() - sb >= 2) begin
            chk("wrap.addr0", q_addr[sb], 64'hFFFF_FFFF_FFFF_FFFC);
            chk("wrap.addr1", q_addr[sb+1], 64'h0);
            chk("wrap.instr1", q_instr[sb+1], 32'h22222222);
        end

        // Overflow on the MAX_WORDS=2 instance.
        do_reset();
        sel = 1'b1;
        sb = nstrobe_b;
        db = ndone_b;
        do_start(64'h1000);
        push_word(32'hA0000001, 1'b0);
        push_word(32'hA0000002, 1'b0);
        push_word(32'hA0000003, 1'b0);
        wait_idle(1'b1);
        tick();
        chk("ovf.strobes", 64'(nstrobe_b - sb), 2);
        chk("ovf.err", err_b, 1);
        chk("ovf.core_rst", crst_b, 1);
        chk("ovf.done_pulses", 64'(ndone_b - db), 0);
        chk("ovf.word_count", wc_b, 2);
        chk("ovf.busy", busy_b, 0);
        do_start(64'h0);
        chk("ovf.err_cleared", err_b, 0);
        sel = 1'b0;

        // Abort during SETUP of word 2, then restart.
        do_reset();
        sb = q_addr.size();
        do_start(64'h40);
        push_word(32'hC0000001, 1'b0);
        push_word(32'hC0000002, 1'b1);
        begin
            int t = 0;
            while (q_addr.size() - sb < 1 && t < 200) begin
                tick();
                t++;
            end
            chk("abort.first_strobe_timeout", 64'(t < 200), 1);
        end
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("abort.core_rst", crst_a, 1);
        chk("abort.wr_en", wr_a, 0);
        chk("abort.dbg_addr", addr_a, 0);
        chk("abort.dbg_instr", instr_a, 0);
        chk("abort.in_ready", ready_a, 0);
        chk("abort.busy", busy_a, 0);
        chk("abort.err", err_a, 0);
        chk("abort.word_count", wc_a, 0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("abort.strobes", 64'(q_addr.size() - sb), 1);
        if (q_addr.size() - sb >= 1) chk("abort.addr0", q_addr[sb], 64'h40);

        sb = q_addr.size();
        db = ndone_a;
        do_start(64'h80);
        push_word(32'hDEADBEEF, 1'b1);
        tick();
        do_start(64'h100);
        load_base = '0;
        wait_idle(1'b0);
        chk("restart.strobes", 64'(q_addr.size() - sb), 1);
        if (q_addr.size() - sb >= 1) begin
            chk("restart.addr", q_addr[sb], 64'h80);
            chk("restart.instr", q_instr[sb], 32'hDEADBEEF);
        end
        chk("restart.done_pulses", 64'(ndone_a - db), 1);
        chk("restart.word_count", wc_a, 1);
        chk("restart.core_rst", crst_a, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
